// File: rtl/cpu_pkg.sv
// Shared encodings and helpers for the single-cycle RV32I-subset core.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    localparam logic [31:0] IO_BASE_DEF = 32'h0000_FF00;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_PASS_B} alu_op_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    typedef struct packed {
        logic    rf_we;
        logic    st;
        wb_sel_e wb_sel;
        alu_op_e alu_op;
        logic    a_pc;
        logic    b_imm;
        logic    beq;
        logic    blt;
        logic    jal;
        logic    jalr;
    } ctrl_t;

    // Unrecognised encodings decode to this: no writes of any kind, pc+4.
    localparam ctrl_t CTRL_NOP = '{rf_we: 1'b0, st: 1'b0, wb_sel: WB_ALU, alu_op: ALU_ADD,
                                   a_pc: 1'b0, b_imm: 1'b0, beq: 1'b0, blt: 1'b0,
                                   jal: 1'b0, jalr: 1'b0};

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one write port.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  rad,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rdd
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    // x0 is forced to zero on every read port regardless of storage.
    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
    assign rdd = (rad == 5'd0) ? '0 : regs[rad];

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I-subset core: ROM fetch, decode, ALU, data RAM and 8-bit I/O window.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
    // ROM image, one word per entry; defaults to all nops (addi x0,x0,0)
    parameter logic [31:0] IMEM_INIT [IMEM_DEPTH] = '{default: 32'h0000_0013}
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din,
    input  logic [7:0]  m_rf_addr,
    output logic [31:0] rf_data,
    output logic [31:0] m_data,
    output logic [31:0] pc
);

    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    logic [31:0] ins, pc_off, pc_plus4, pc_imm, npc;
    logic [31:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, alu_y, ea, wd, ld_v;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        io_hit, ram_we, br_taken;
    ctrl_t       c;
    logic [31:0] dmem [DMEM_DEPTH];

    // Fetch: index is the word offset from PC_RESET, wrapping modulo ROM depth.
    assign pc_off = pc - PC_RESET;
    assign ins    = IMEM_INIT[pc_off[IA_W+1:2]];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_off[31:IA_W+2], pc_off[1:0]};

    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        c   = CTRL_NOP;
        imm = imm_i;
        case (opcode)
            OP_R: begin
                if (f3 == F3_ADD && f7 == F7_BASE) begin
                    c.rf_we = 1'b1; c.alu_op = ALU_ADD;
                end else if (f3 == F3_ADD && f7 == F7_SUB) begin
                    c.rf_we = 1'b1; c.alu_op = ALU_SUB;
                end else if (f3 == F3_AND && f7 == F7_BASE) begin
                    c.rf_we = 1'b1; c.alu_op = ALU_AND;
                end else if (f3 == F3_OR && f7 == F7_BASE) begin
                    c.rf_we = 1'b1; c.alu_op = ALU_OR;
                end
            end
            OP_I: if (f3 == F3_ADD) begin
                c.rf_we = 1'b1; c.b_imm = 1'b1;
            end
            OP_LUI: begin
                imm = imm_u; c.rf_we = 1'b1; c.b_imm = 1'b1; c.alu_op = ALU_PASS_B;
            end
            OP_AUIPC: begin
                imm = imm_u; c.rf_we = 1'b1; c.b_imm = 1'b1; c.a_pc = 1'b1;
            end
            OP_LOAD: if (f3 == F3_LW) begin
                c.rf_we = 1'b1; c.wb_sel = WB_MEM;
            end
            OP_STORE: begin
                imm = imm_s;
                c.st = (f3 == F3_SW);
            end
            OP_BRANCH: begin
                imm = imm_b;
                c.beq = (f3 == F3_BEQ);
                c.blt = (f3 == F3_BLT);
            end
            OP_JAL: begin
                imm = imm_j; c.rf_we = 1'b1; c.wb_sel = WB_PC4; c.jal = 1'b1;
            end
            OP_JALR: if (f3 == F3_JALR) begin
                c.rf_we = 1'b1; c.wb_sel = WB_PC4; c.jalr = 1'b1;
            end
            default: ;
        endcase
    end

    cpu_regfile u_rf (
        .clk   (clk),
        .rst_n (rst),
        .ra1   (ins[19:15]),
        .ra2   (ins[24:20]),
        .rad   (m_rf_addr[4:0]),
        .we    (c.rf_we),
        .wa    (ins[11:7]),
        .wd    (wd),
        .rd1   (rs1_v),
        .rd2   (rs2_v),
        .rdd   (rf_data)
    );

    assign alu_y = alu(c.alu_op, c.a_pc ? pc : rs1_v, c.b_imm ? imm : rs2_v);

    // Effective address doubles as the jalr target before clearing bit 0.
    assign ea     = rs1_v + imm;
    assign io_hit = (ea[31:8] == IO_BASE[31:8]);
    assign ld_v   = io_hit ? io_din : dmem[ea[DA_W+1:2]];

    always_comb begin
        case (c.wb_sel)
            WB_MEM:  wd = ld_v;
            WB_PC4:  wd = pc_plus4;
            default: wd = alu_y;
        endcase
    end

    assign io_addr = ea[7:0];
    assign io_dout = rs2_v;
    assign io_we   = rst & c.st & io_hit;
    assign ram_we  = rst & c.st & ~io_hit;

    always_ff @(posedge clk) begin
        if (ram_we) dmem[ea[DA_W+1:2]] <= rs2_v;
    end

    assign m_data = dmem[m_rf_addr[DA_W-1:0]];

    assign pc_plus4 = pc + 32'd4;
    assign pc_imm   = pc + imm;
    assign br_taken = (c.beq && rs1_v == rs2_v) || (c.blt && $signed(rs1_v) < $signed(rs2_v));

    always_comb begin
        if (c.jalr)                 npc = {ea[31:1], 1'b0};
        else if (c.jal || br_taken) npc = pc_imm;
        else                        npc = pc_plus4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= PC_RESET;
        else      pc <= npc;
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: PC-trace and I/O-write scoreboards plus final RF/RAM state.
`timescale 1ns/100ps
module tb_cpu;

    typedef logic [31:0] rom_t [256];
    typedef struct packed { logic [7:0] addr; logic [31:0] dout; } io_exp_t;

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_ins(input logic [31:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {im[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_ins(input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_ins(input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] u_ins(input logic [31:0] im, input logic [4:0] rd, input logic [6:0] op);
        return {im[19:0], rd, op};
    endfunction
    function automatic logic [31:0] j_ins(input logic [31:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] im);
        return i_ins(im, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic rom_t build_prog();
        rom_t p;
        for (int i = 0; i < 256; i++) p[i] = 32'h0000_0013;
        p[0]  = addi(5'd8, 5'd0, 32'd5);
        p[1]  = addi(5'd9, 5'd0, -32'sd3);
        p[2]  = r_ins(7'h00, 5'd9, 5'd8, 3'b000, 5'd3);         // add x3,x8,x9
        p[3]  = r_ins(7'h20, 5'd9, 5'd8, 3'b000, 5'd4);         // sub x4,x8,x9
        p[4]  = s_ins(32'd8, 5'd3, 5'd0);                       // sw x3,8(x0)
        p[5]  = i_ins(32'd8, 5'd0, 3'b010, 5'd5, 7'b0000011);   // lw x5,8(x0)
        p[6]  = u_ins(32'h10, 5'd10, 7'b0110111);               // lui x10,0x10
        p[7]  = addi(5'd10, 5'd10, -32'sd256);                  // x10 = 0xFF00
        p[8]  = i_ins(32'd8, 5'd10, 3'b010, 5'd6, 7'b0000011);  // lw x6,8(x10)
        p[9]  = s_ins(32'd12, 5'd8, 5'd10);                     // sw x8,12(x10)
        p[10] = b_ins(32'd8, 5'd8, 5'd9, 3'b100);               // blt x9,x8,+8
        p[11] = addi(5'd11, 5'd0, 32'd1);                       // skipped
        p[12] = b_ins(32'd8, 5'd9, 5'd8, 3'b000);               // beq x8,x9,+8
        p[13] = j_ins(32'd28, 5'd1);                            // jal x1,+28
        p[14] = addi(5'd12, 5'd0, 32'h77);
        p[15] = u_ins(32'h1, 5'd13, 7'b0010111);                // auipc x13,1
        p[16] = r_ins(7'h00, 5'd9, 5'd8, 3'b111, 5'd14);        // and
        p[17] = r_ins(7'h00, 5'd9, 5'd8, 3'b110, 5'd15);        // or
        p[18] = j_ins(32'd0, 5'd0);                             // spin
        p[20] = addi(5'd0, 5'd0, 32'd7);
        p[21] = 32'h0000_0000;
        p[22] = i_ins(32'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);   // jalr x0,0(x1)
        return p;
    endfunction

    localparam rom_t PROG = build_prog();

    logic        clk, rst, io_we;
    logic [7:0]  io_addr, m_rf_addr;
    logic [31:0] io_dout, io_din, rf_data, m_data, pc;

    cpu #(.IMEM_INIT(PROG)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_we     (io_we),
        .io_din    (io_din),
        .m_rf_addr (m_rf_addr),
        .rf_data   (rf_data),
        .m_data    (m_data),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] pc_q [$];
    io_exp_t     io_q [$];
    logic [31:0] exp_rf [32];

    initial begin
        logic [31:0] e_pc;
        io_exp_t     e_io;

        rst = 1'b0; io_din = 32'd1; m_rf_addr = 8'd0;
        #2;
        for (int i = 0; i < 32; i++) begin
            m_rf_addr = 8'(i);
            #0.5;
            chk($sformatf("rst_rf%0d", i), rf_data, 32'd0);
        end
        chk("rst_pc", pc, 32'h3000);
        chk("rst_io_we", {31'd0, io_we}, 32'd0);

        // Expected retirement trace and I/O writes, derived from the program above.
        for (int i = 0; i <= 10; i++) pc_q.push_back(32'h3000 + 32'(4 * i));
        pc_q.push_back(32'h3030); pc_q.push_back(32'h3034); pc_q.push_back(32'h3050);
        pc_q.push_back(32'h3054); pc_q.push_back(32'h3058); pc_q.push_back(32'h3038);
        pc_q.push_back(32'h303C); pc_q.push_back(32'h3040); pc_q.push_back(32'h3044);
        for (int i = 0; i < 3; i++) pc_q.push_back(32'h3048);
        io_q.push_back('{addr: 8'h0C, dout: 32'd5});

        @(negedge clk);
        rst = 1'b1;
        while (pc_q.size() > 0) begin
            e_pc = pc_q.pop_front();
            chk("pc_trace", pc, e_pc);
            if (io_we) begin
                if (io_q.size() == 0) chk("io_we_extra", 32'd1, 32'd0);
                else begin
                    e_io = io_q.pop_front();
                    chk("io_addr", {24'd0, io_addr}, {24'd0, e_io.addr});
                    chk("io_dout", io_dout, e_io.dout);
                end
            end
            @(negedge clk);
        end
        chk("io_pulses_left", 32'(io_q.size()), 32'd0);

        for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
        exp_rf[1]  = 32'h3038;     exp_rf[3]  = 32'd2;       exp_rf[4]  = 32'd8;
        exp_rf[5]  = 32'd2;        exp_rf[6]  = 32'd1;       exp_rf[8]  = 32'd5;
        exp_rf[9]  = 32'hFFFF_FFFD; exp_rf[10] = 32'h0000_FF00; exp_rf[12] = 32'h77;
        exp_rf[13] = 32'h403C;     exp_rf[14] = 32'd5;       exp_rf[15] = 32'hFFFF_FFFD;
        for (int i = 0; i < 32; i++) begin
            m_rf_addr = 8'(i);
            #1;
            chk($sformatf("rf_x%0d", i), rf_data, exp_rf[i]);
        end
        m_rf_addr = 8'd2;
        #1;
        chk("dmem_w2", m_data, 32'd2);

        // Mid-program reset: PC and RF clear, RAM keeps its contents.
        @(negedge clk);
        rst = 1'b0;
        m_rf_addr = 8'd3;
        #1;
        chk("rst2_pc", pc, 32'h3000);
        chk("rst2_x3", rf_data, 32'd0);
        m_rf_addr = 8'd2;
        #1;
        chk("rst2_dmem", m_data, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_step", pc, 32'h3004);
        m_rf_addr = 8'd8;
        #1;
        chk("rst2_x8", rf_data, 32'd5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
